// File: rtl/rv32i_fetch_buffer.sv
// Instruction prefetch queue: sequential word fetch, in-order responses, PC-tagged FIFO to the core.
// Response to instr_valid is 1 cycle; requests stop when FIFO space plus in-flight credits run out.

module rv32i_fetch_buffer_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push_vld,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop_rdy,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + AW'(1);
         if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_vld) - CW'(pop_rdy);
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld && !flush && !rst) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
endmodule

module rv32i_fetch_buffer #(
   parameter logic [31:0] START_ADDRESS   = 32'h0,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);
   localparam int            CW      = $clog2(DEPTH+1);
   localparam int            CW1     = CW + 1;
   localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
   localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
   } fetch_entry_t;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   redirect_pc_al;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_count;
   logic [CW:0]   credits_used;
   logic          req_acc;
   logic          rsp_drop;
   logic          rsp_push;
   logic          pop;
   fetch_entry_t  push_entry;
   fetch_entry_t  head_entry;

   // Every in-flight request holds a FIFO slot unless its response is already doomed to be dropped.
   assign credits_used   = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop_count};
   assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

   assign mem_req_valid = ena && !redirect && !rst
                        && (outstanding < MAX_OUT) && (credits_used < DEPTH_W);
   assign mem_req_addr  = fetch_pc;
   assign req_acc       = mem_req_valid && mem_req_ready;

   assign rsp_drop = mem_rsp_valid && (drop_count != '0);
   assign rsp_push = mem_rsp_valid && (drop_count == '0) && !redirect;

   assign instr_valid = ena && !redirect && !rst && (count != '0);
   assign pop         = instr_valid && instr_ready;

   assign push_entry = '{data: mem_rsp_data, pc: rsp_pc};

   rv32i_fetch_buffer_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .push_vld (rsp_push),
      .push_dat (push_entry),
      .pop_rdy  (pop),
      .head_dat (head_entry),
      .count    (count)
   );

   assign instr    = instr_valid ? head_entry.data : NOP;
   assign instr_pc = instr_valid ? head_entry.pc   : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= START_ADDRESS;
         rsp_pc      <= START_ADDRESS;
         outstanding <= '0;
         drop_count  <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_acc) - CW'(mem_rsp_valid);
         if (redirect) begin
            // Whatever is still in flight after this cycle belongs to the old path.
            fetch_pc   <= redirect_pc_al;
            rsp_pc     <= redirect_pc_al;
            drop_count <= outstanding - CW'(mem_rsp_valid);
         end else begin
            if (req_acc)  fetch_pc   <= fetch_pc + 32'd4;
            if (rsp_push) rsp_pc     <= rsp_pc + 32'd4;
            if (rsp_drop) drop_count <= drop_count - CW'(1);
         end
      end
   end

   a_credit: assert property (@(posedge clk) disable iff (rst) credits_used <= DEPTH_W);
   a_outst:  assert property (@(posedge clk) disable iff (rst) outstanding <= MAX_OUT);
   a_drop:   assert property (@(posedge clk) disable iff (rst) drop_count <= outstanding);
endmodule

// File: tb/tb_rv32i_fetch_buffer.sv
// Randomised bench for rv32i_fetch_buffer: in-order memory model plus an expected-PC stream scoreboard.
module tb_rv32i_fetch_buffer;
   localparam int          MAXO  = 2;
   localparam logic [31:0] START = 32'h0;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, ena, redirect, mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic        instr_valid, instr_ready;
   logic [31:0] redirect_pc, mem_req_addr, mem_rsp_data, instr, instr_pc;

   always #5 clk = ~clk;

   rv32i_fetch_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .ena           (ena),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc)
   );

   int          checks = 0;
   int          failures = 0;
   int          lat, rdy_pct, ird_pct;
   int          cyc = 0;
   int          s_cyc;
   int          n_pop = 0;
   logic        s_req_v, s_iv;
   logic [31:0] s_addr;
   logic [31:0] exp_pc, exp_req;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: observe at negedge, update model, then drive memory and readies after the edge.
   task automatic tick();
      logic acc, popped;
      int   due;
      @(negedge clk);
      s_cyc   = cyc;
      s_req_v = mem_req_valid;
      s_addr  = mem_req_addr;
      s_iv    = instr_valid;
      if (rst) begin
         check("rst_req_v", mem_req_valid, 1'b0);
         mq_addr.delete();
         mq_due.delete();
         exp_pc  = START;
         exp_req = START;
      end else begin
         if (redirect || !ena) begin
            check("blocked_req_v", mem_req_valid, 1'b0);
            check("blocked_iv", instr_valid, 1'b0);
         end
         if (!instr_valid) begin
            check("idle_instr", instr, NOP);
            check("idle_pc", instr_pc, 32'h0);
         end
         acc    = mem_req_valid && mem_req_ready;
         popped = instr_valid && instr_ready;
         if (acc) begin
            check("req_addr", mem_req_addr, exp_req);
            acc_log.push_back(mem_req_addr);
            due = s_cyc + lat;
            if (mq_due.size() > 0 && due <= mq_due[$]) due = mq_due[$] + 1;
            mq_addr.push_back(mem_req_addr);
            mq_due.push_back(due);
            check("outstanding_le_max", mq_addr.size() <= MAXO, 1'b1);
            exp_req += 32'd4;
         end
         if (popped) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, memf(exp_pc));
            pop_log.push_back(instr_pc);
            exp_pc += 32'd4;
            n_pop++;
         end
         if (redirect) begin
            exp_pc  = {redirect_pc[31:2], 2'b00};
            exp_req = exp_pc;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = memf(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = $urandom;
      end
      mem_req_ready = ($urandom_range(99) < rdy_pct);
      instr_ready   = ($urandom_range(99) < ird_pct);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      ena      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  fr, fi, n0, bad;
      bit  found;
      rst = 1'b1; ena = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      mem_req_ready = 1'b1; instr_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
      lat = 1; rdy_pct = 100; ird_pct = 100;

      // Streaming from reset with a 1-cycle memory
      do_reset();
      fr = -1; fi = -1;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (i == 0) begin
            check("rst_iv", s_iv, 1'b0);
            check("rst_req_v_after", s_req_v, 1'b1);
            check("rst_addr", s_addr, START);
         end
         if (s_req_v && fr < 0) fr = s_cyc;
         if (s_iv && fi < 0) fi = s_cyc;
         else if (fi >= 0 && s_cyc <= fi + 8) check("t1_stream", s_iv, 1'b1);
      end
      check("t1_latency", fi - fr, 2);

      // Core stalled: FIFO fills to DEPTH, then drains and fetch resumes
      ird_pct = 0;
      do_reset();
      acc_log.delete(); pop_log.delete();
      repeat (15) tick();
      check("t2_reqs", acc_log.size(), 4);
      check("t2_full_req_v", s_req_v, 1'b0);
      check("t2_full_iv", s_iv, 1'b1);
      ird_pct = 100;
      repeat (12) tick();
      check("t2_progress", pop_log.size() >= 4 && acc_log.size() >= 5, 1'b1);
      if (pop_log.size() >= 4 && acc_log.size() >= 5) begin
         for (int k = 0; k < 4; k++) check("t2_pop_pc", pop_log[k], 32'(k * 4));
         check("t2_resume_addr", acc_log[4], 32'h10);
      end

      // Redirect with two requests in flight on a 3-cycle memory
      lat = 3;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (mq_addr.size() == 2 && !mem_rsp_valid) found = 1'b1;
      end
      check("t3_inflight", found, 1'b1);
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      pop_log.delete();
      repeat (20) tick();
      check("t3_pops", pop_log.size() >= 2, 1'b1);
      if (pop_log.size() >= 2) begin
         check("t3_first_pc", pop_log[0], 32'h100);
         check("t3_second_pc", pop_log[1], 32'h104);
      end

      // Unaligned redirect coinciding with a response
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (mem_rsp_valid) found = 1'b1;
      end
      check("t4_rsp_seen", found, 1'b1);
      redirect = 1'b1; redirect_pc = 32'h103;
      acc_log.delete(); pop_log.delete();
      tick();
      redirect = 1'b0;
      repeat (20) tick();
      check("t4_addr", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h100);
      check("t4_pop_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

      // Random ready, random redirects (some near the PC wrap), varying latency
      rdy_pct = 60; ird_pct = 70;
      do_reset();
      n0 = n_pop;
      for (int i = 0; i < 1500; i++) begin
         lat = (i < 750) ? 3 : $urandom_range(4, 1);
         redirect    = ($urandom_range(39) == 0);
         redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         tick();
      end
      redirect = 1'b0;
      check("t5_progress", (n_pop - n0) > 150, 1'b1);

      // Enable held low mid-stream, then reset mid-stream
      lat = 2; rdy_pct = 100; ird_pct = 100;
      do_reset();
      repeat (10) tick();
      ena = 1'b0; bad = 0; n0 = n_pop;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (s_req_v || s_iv) bad++;
      end
      check("t6_quiet", bad, 0);
      check("t6_no_pop", n_pop - n0, 0);
      ena = 1'b1;
      repeat (15) tick();
      check("t6_resume", (n_pop - n0) > 5, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pop_log.delete();
      repeat (10) tick();
      check("t6_rst_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, START);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
